// File: rtl/approx_mult_pkg.sv
// Shared types and constants for the approximate-multiplier evaluation blocks.
// Holds the divider FSM state type, default widths and the divide-by-zero quotient fill.
`timescale 1ns/1ps
package approx_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int unsigned DW_DEFAULT = 16;
    localparam int unsigned VW_DEFAULT = 8;

    // Every quotient bit takes this value when the divisor is zero.
    localparam logic DBZ_Q_FILL = 1'b1;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference only if it did not go negative.
`timescale 1ns/1ps
module div_step #(
    parameter int unsigned VW = 8
) (
    input  logic [VW:0]   p,
    input  logic          qr_msb,
    input  logic [VW-1:0] divisor,
    output logic [VW:0]   p_next,
    output logic          q_bit
);

    logic [VW:0]   shifted_s;
    logic [VW+1:0] trial_s;
    // The partial remainder stays below the divisor, so its top bit is always zero.
    logic          unused_p_msb_s;

    assign unused_p_msb_s = p[VW];
    assign shifted_s      = {p[VW-1:0], qr_msb};
    assign trial_s        = {1'b0, shifted_s} - {2'b00, divisor};

    // Select trial difference or restored value from the borrow bit.
    always_comb begin
        p_next = shifted_s;
        q_bit  = 1'b0;
        if (!trial_s[VW+1]) begin
            p_next = trial_s[VW:0];
            q_bit  = 1'b1;
        end else begin
            p_next = shifted_s;
            q_bit  = 1'b0;
        end
    end

endmodule

// File: rtl/div_16x8_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock, with
// valid/ready handshakes on operands and results.
`timescale 1ns/1ps
module div_16x8_seq
    import approx_mult_pkg::*;
#(
    parameter int unsigned DW = DW_DEFAULT,
    parameter int unsigned VW = VW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] DIVIDEND,
    input  logic [VW-1:0] DIVISOR,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] Q,
    output logic [VW-1:0] REM,
    output logic          DBZ
);

    localparam int unsigned CW = $clog2(DW);

    div_state_t    state_r;
    logic [VW:0]   p_r;
    logic [DW-1:0] qr_r;
    logic [VW-1:0] divisor_r;
    logic [CW-1:0] count_r;
    logic          in_ready_r;
    logic          out_valid_r;
    logic [DW-1:0] q_r;
    logic [VW-1:0] rem_r;
    logic          dbz_r;

    logic [VW:0]   p_next_s;
    logic          q_bit_s;
    logic [DW-1:0] qr_next_s;

    div_step #(.VW(VW)) u_step (
        .p       (p_r),
        .qr_msb  (qr_r[DW-1]),
        .divisor (divisor_r),
        .p_next  (p_next_s),
        .q_bit   (q_bit_s)
    );

    assign qr_next_s = {qr_r[DW-2:0], q_bit_s};

    // Control FSM, iteration datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            p_r         <= {(VW+1){1'b0}};
            qr_r        <= {DW{1'b0}};
            divisor_r   <= {VW{1'b0}};
            count_r     <= {CW{1'b0}};
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            q_r         <= {DW{1'b0}};
            rem_r       <= {VW{1'b0}};
            dbz_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    in_ready_r <= 1'b1;
                    if (in_valid && in_ready_r) begin
                        in_ready_r <= 1'b0;
                        if (DIVISOR == {VW{1'b0}}) begin
                            state_r     <= DONE;
                            q_r         <= {DW{DBZ_Q_FILL}};
                            rem_r       <= DIVIDEND[VW-1:0];
                            dbz_r       <= 1'b1;
                            out_valid_r <= 1'b1;
                        end else begin
                            state_r   <= BUSY;
                            p_r       <= {(VW+1){1'b0}};
                            qr_r      <= DIVIDEND;
                            divisor_r <= DIVISOR;
                            count_r   <= CW'(DW - 1);
                        end
                    end
                end
                BUSY: begin
                    p_r     <= p_next_s;
                    qr_r    <= qr_next_s;
                    count_r <= count_r - CW'(1);
                    // The final iteration writes the results straight from the step outputs.
                    if (count_r == {CW{1'b0}}) begin
                        state_r     <= DONE;
                        count_r     <= {CW{1'b0}};
                        q_r         <= qr_next_s;
                        rem_r       <= p_next_s[VW-1:0];
                        dbz_r       <= 1'b0;
                        out_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign Q         = q_r;
    assign REM       = rem_r;
    assign DBZ       = dbz_r;

endmodule

// File: tb/tb_div_16x8_seq.sv
// Bench for div_16x8_seq: directed and random divisions checked by a queue-based
// scoreboard against plain integer division.
`timescale 1ns/1ps
module tb_div_16x8_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] q;
    logic [7:0]  rem;
    logic        dbz;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit seen  = 1'b0;
    bit rnd_ready = 1'b0;

    typedef struct {
        logic [15:0] q;
        logic [7:0]  rem;
        logic        dbz;
        int          acc_cyc;
        int          lat;
    } exp_t;

    exp_t sb[$];

    div_16x8_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .DIVIDEND  (dividend),
        .DIVISOR   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Q         (q),
        .REM       (rem),
        .DBZ       (dbz)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [7:0] b, input int acc);
        exp_t e;
        int   ia;
        int   ib;
        ia = int'(a);
        ib = int'(b);
        e.acc_cyc = acc;
        if (ib == 0) begin
            e.q   = 16'hFFFF;
            e.rem = a[7:0];
            e.dbz = 1'b1;
            e.lat = 1;
        end else begin
            e.q   = 16'(ia / ib);
            e.rem = 8'(ia % ib);
            e.dbz = 1'b0;
            e.lat = 17;
        end
        return e;
    endfunction

    // Monitor: compares every presented result against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen = 1'b0;
            end else if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_result_queue_size", 32'(sb.size()), 32'd1);
                end else begin
                    if (!seen) begin
                        chk("latency", 32'(cyc - sb[0].acc_cyc + 1), 32'(sb[0].lat));
                        seen = 1'b1;
                    end
                    chk("Q", 32'(q), 32'(sb[0].q));
                    chk("REM", 32'(rem), 32'(sb[0].rem));
                    chk("DBZ", 32'(dbz), 32'(sb[0].dbz));
                    chk("in_ready_in_done", 32'(in_ready), 32'd0);
                    if (out_ready) begin
                        void'(sb.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    // Random backpressure on the result port when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic issue(input logic [15:0] a, input logic [7:0] b);
        bit ok;
        ok       = 1'b0;
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        if (ok) sb.push_back(model(a, b, cyc));
        else    chk("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) chk("drain_timeout_queue_size", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rel;
        bit ok;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = 16'h0000;
        divisor   = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_Q", 32'(q), 32'd0);
        chk("rst_REM", 32'(rem), 32'd0);
        chk("rst_DBZ", 32'(dbz), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(16'hFFFF, 8'hFF); drain();
        issue(16'h1234, 8'h07); drain();
        issue(16'h0005, 8'h09); drain();
        issue(16'h0000, 8'h01); drain();
        issue(16'hABCD, 8'h00); drain();

        // Backpressure: result held, second request ignored until release.
        out_ready = 1'b0;
        issue(16'h4321, 8'h0D);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (out_valid) ok = 1'b1;
        end
        if (!ok) chk("bp_wait_out_valid", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        dividend = 16'h0BAD;
        divisor  = 8'h11;
        in_valid = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        chk("bp_result_still_pending", 32'(sb.size()), 32'd1);
        out_ready = 1'b1;
        rel = cyc;
        ok  = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            else begin
                @(posedge clk);
            end
        end
        if (ok) chk("accept_after_release", 32'(cyc - rel), 32'd1);
        else    chk("accept_after_release_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        sb.push_back(model(16'h0BAD, 8'h11, cyc));
        in_valid = 1'b0;
        drain();

        // Abort in the middle of a divide.
        issue(16'h1234, 8'h07);
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_Q", 32'(q), 32'd0);
        chk("abort_REM", 32'(rem), 32'd0);
        chk("abort_DBZ", 32'(dbz), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        sb.delete();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(16'h0064, 8'h0A); drain();

        rnd_ready = 1'b1;
        for (int k = 0; k < 60; k++) begin
            logic [15:0] ra;
            logic [7:0]  rb;
            ra = 16'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            issue(ra, rb);
        end
        drain();
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
